// File: rtl/alu_add_issue_if.sv
// Bundles the request, result and adder-side signals of alu_add_issue.
// The slave modport is the issue block; the master modport is its environment.
interface alu_add_issue_if #(
   parameter int IN_WL  = 15,
   parameter int OUT_WL = 16,
   parameter int TAG_W  = 4,
   parameter int DEPTH  = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [IN_WL-1:0]  in_a;
   logic [IN_WL-1:0]  in_b;
   logic [TAG_W-1:0]  in_tag;
   logic [IN_WL-1:0]  add_a;
   logic [IN_WL-1:0]  add_b;
   logic [OUT_WL-1:0] add_r;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_WL-1:0] out_r;
   logic [TAG_W-1:0]  out_tag;
   logic [LW-1:0]     level;

   modport master (
      output in_valid, in_a, in_b, in_tag, out_ready, add_r,
      input  in_ready, add_a, add_b, out_valid, out_r, out_tag, level
   );

   modport slave (
      input  in_valid, in_a, in_b, in_tag, out_ready, add_r,
      output in_ready, add_a, add_b, out_valid, out_r, out_tag, level
   );
endinterface

// File: rtl/alu_add_issue.sv
// Issues operand pairs to an external 1-cycle adder, tracks tags through a
// two-stage valid pipeline and buffers results in order in a small FIFO.
module alu_add_issue #(
   parameter int IN_WL  = 15,
   parameter int OUT_WL = 16,
   parameter int TAG_W  = 4,
   parameter int DEPTH  = 4
) (
   input  logic         clk,
   input  logic         rstb,
   alu_add_issue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic                    v1_r;
   logic                    v2_r;
   logic [TAG_W-1:0]        tag1_r;
   logic [TAG_W-1:0]        tag2_r;
   logic [IN_WL-1:0]        add_a_r;
   logic [IN_WL-1:0]        add_b_r;
   logic [OUT_WL+TAG_W-1:0] mem_r [DEPTH];
   logic [PW-1:0]           wptr_r;
   logic [PW-1:0]           rptr_r;
   logic [LW-1:0]           level_r;

   logic [LW:0]             inflight_s;
   logic                    in_ready_s;
   logic                    out_valid_s;
   logic                    accept_s;
   logic                    pop_s;
   logic [LW-1:0]           level_nx_s;

   // Credit check counts every result already committed to a FIFO slot.
   always_comb begin
      inflight_s  = {1'b0, level_r} + {{LW{1'b0}}, v1_r} + {{LW{1'b0}}, v2_r};
      in_ready_s  = (inflight_s < (LW+1)'(DEPTH));
      out_valid_s = (level_r != {LW{1'b0}});
      accept_s    = bus.in_valid & in_ready_s;
      pop_s       = out_valid_s & bus.out_ready;
      if (v2_r && !pop_s) begin
         level_nx_s = level_r + LW'(1);
      end else if (!v2_r && pop_s) begin
         level_nx_s = level_r - LW'(1);
      end else begin
         level_nx_s = level_r;
      end
   end

   // Stage 1: launch operands to the adder and remember the tag.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         v1_r    <= 1'b0;
         tag1_r  <= {TAG_W{1'b0}};
         add_a_r <= {IN_WL{1'b0}};
         add_b_r <= {IN_WL{1'b0}};
      end else begin
         v1_r <= accept_s;
         if (accept_s) begin
            tag1_r  <= bus.in_tag;
            add_a_r <= bus.in_a;
            add_b_r <= bus.in_b;
         end
      end
   end

   // Stage 2: valid/tag line up with add_r from the external adder.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         v2_r   <= 1'b0;
         tag2_r <= {TAG_W{1'b0}};
      end else begin
         v2_r   <= v1_r;
         tag2_r <= tag1_r;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2^PW.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         wptr_r  <= {PW{1'b0}};
         rptr_r  <= {PW{1'b0}};
         level_r <= {LW{1'b0}};
      end else begin
         if (v2_r) begin
            wptr_r <= wptr_r + PW'(1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + PW'(1);
         end
         level_r <= level_nx_s;
      end
   end

   // FIFO storage; contents are only observed while level is non-zero.
   always_ff @(posedge clk) begin
      if (v2_r) begin
         mem_r[wptr_r] <= {bus.add_r, tag2_r};
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.add_a     = add_a_r;
   assign bus.add_b     = add_b_r;
   assign bus.level     = level_r;
   assign {bus.out_r, bus.out_tag} = mem_r[rptr_r];
endmodule

// File: tb/tb_alu_add_issue.sv
// Randomised and directed bench for alu_add_issue against a queue-based
// transaction model; also provides the external registered adder.
module tb_alu_add_issue;
   localparam int IN_WL  = 15;
   localparam int OUT_WL = 16;
   localparam int TAG_W  = 4;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rstb;
   always #5 clk = ~clk;

   alu_add_issue_if #(.IN_WL(IN_WL), .OUT_WL(OUT_WL), .TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

   alu_add_issue #(.IN_WL(IN_WL), .OUT_WL(OUT_WL), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   // External adder: registered, one edge of latency.
   always_ff @(posedge clk) begin
      bus.add_r <= {bus.add_a[IN_WL-1], bus.add_a} + {bus.add_b[IN_WL-1], bus.add_b};
   end

   typedef struct {
      logic [OUT_WL-1:0] r;
      logic [TAG_W-1:0]  tag;
      int                acc;
   } ent_t;

   ent_t              q[$];
   logic [TAG_W-1:0]  pop_tag_q[$];
   int                pop_cyc_q[$];
   int                cyc    = 0;
   int                n_chk  = 0;
   int                n_pass = 0;
   int                n_acc  = 0;
   bit                chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, obs, exp, cyc);
      end
   endtask

   function automatic logic [OUT_WL-1:0] ref_sum(input logic [IN_WL-1:0] a, input logic [IN_WL-1:0] b);
      int sa;
      int sb;
      int s;
      sa = $signed(a);
      sb = $signed(b);
      s  = sa + sb;
      return s[OUT_WL-1:0];
   endfunction

   function automatic logic [IN_WL-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 15'h4000;
         1:       return 15'h3FFF;
         2:       return 15'h7FFF;
         default: return IN_WL'($urandom);
      endcase
   endfunction

   // One clock: compare outputs against the model, then advance the model.
   task automatic step();
      int   vis;
      bit   exp_rdy;
      bit   exp_vld;
      bit   acc;
      bit   pop;
      ent_t e;
      vis = 0;
      foreach (q[i]) if (q[i].acc + 2 <= cyc) vis++;
      exp_rdy = (q.size() < DEPTH);
      exp_vld = (vis > 0);
      if (chk_en) begin
         chk("in_ready", bus.in_ready, exp_rdy);
         chk("out_valid", bus.out_valid, exp_vld);
         chk("level", bus.level, vis);
         if (exp_vld) begin
            chk("out_r", bus.out_r, q[0].r);
            chk("out_tag", bus.out_tag, q[0].tag);
         end
      end
      acc = rstb && bus.in_valid && exp_rdy;
      pop = rstb && exp_vld && bus.out_ready;
      e.r   = ref_sum(bus.in_a, bus.in_b);
      e.tag = bus.in_tag;
      e.acc = 0;
      if (pop) begin
         pop_tag_q.push_back(bus.out_tag);
         pop_cyc_q.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      if (!rstb) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) begin
            e.acc = cyc;
            q.push_back(e);
            n_acc++;
         end
      end
      #1;
   endtask

   task automatic run_single(input logic [IN_WL-1:0] a, input logic [IN_WL-1:0] b,
                             input logic [TAG_W-1:0] tag, input logic [OUT_WL-1:0] exp_r);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_tag    = tag;
      step();
      bus.in_valid = 1'b0;
      step();
      chk("single_early", bus.out_valid, 1'b0);
      step();
      chk("single_valid", bus.out_valid, 1'b1);
      chk("single_r", bus.out_r, exp_r);
      chk("single_tag", bus.out_tag, tag);
      step();
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int k;
      int budget;
      int acc0;
      bit rdy_now;

      rstb          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = {IN_WL{1'b0}};
      bus.in_b      = {IN_WL{1'b0}};
      bus.in_tag    = {TAG_W{1'b0}};
      bus.out_ready = 1'b0;
      repeat (3) step();
      rstb = 1'b1;
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_level", bus.level, 0);
      chk("rst_add_a", bus.add_a, 0);
      chk("rst_add_b", bus.add_b, 0);
      chk_en = 1'b1;

      run_single(15'h0005, 15'h7FFD, 4'd2, 16'h0002);
      run_single(15'h4000, 15'h4000, 4'd7, 16'h8000);
      run_single(15'h3FFF, 15'h3FFF, 4'd9, 16'h7FFE);

      // Backpressure: fill to DEPTH with the consumer stalled.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         bus.in_tag = TAG_W'(k);
         bus.in_a   = rnd_op();
         bus.in_b   = rnd_op();
         rdy_now    = bus.in_ready;
         step();
         if (rdy_now) k++;
      end
      chk("bp_accepts", k, DEPTH);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_level", bus.level, DEPTH);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      pop_tag_q.delete();
      budget = 20;
      while (pop_tag_q.size() < DEPTH && budget > 0) begin
         step();
         budget--;
      end
      chk("bp_pops", pop_tag_q.size(), DEPTH);
      foreach (pop_tag_q[i]) chk("bp_tag_order", pop_tag_q[i], i);
      chk("bp_ready_back", bus.in_ready, 1'b1);

      // Streaming: accepts and pops every cycle.
      pop_tag_q.delete();
      pop_cyc_q.delete();
      for (int i = 0; i < 16; i++) begin
         bus.in_valid = 1'b1;
         bus.in_tag   = TAG_W'(i);
         bus.in_a     = rnd_op();
         bus.in_b     = rnd_op();
         chk("stream_rdy", bus.in_ready, 1'b1);
         step();
      end
      bus.in_valid = 1'b0;
      budget = 10;
      while (pop_tag_q.size() < 16 && budget > 0) begin
         step();
         budget--;
      end
      chk("stream_pops", pop_tag_q.size(), 16);
      foreach (pop_tag_q[i]) chk("stream_tag", pop_tag_q[i], i);
      if (pop_cyc_q.size() == 16) chk("stream_span", pop_cyc_q[15] - pop_cyc_q[0], 15);

      // Reset while stage 1, stage 2 and the FIFO all hold work.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_tag   = TAG_W'(i + 4);
         bus.in_a     = rnd_op();
         bus.in_b     = rnd_op();
         step();
      end
      chk("mr_level_pre", bus.level, 1);
      rstb = 1'b0;
      step();
      rstb         = 1'b1;
      bus.in_valid = 1'b0;
      chk("mr_out_valid", bus.out_valid, 1'b0);
      chk("mr_level", bus.level, 0);
      chk("mr_in_ready", bus.in_ready, 1'b1);
      bus.out_ready = 1'b1;
      pop_tag_q.delete();
      repeat (6) step();
      chk("mr_no_stale", pop_tag_q.size(), 0);

      // Random traffic on both sides.
      acc0   = n_acc;
      budget = 40000;
      while ((n_acc - acc0) < 10000 && budget > 0) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_a      = rnd_op();
         bus.in_b      = rnd_op();
         bus.in_tag    = TAG_W'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
         budget--;
      end
      chk("rand_accepts", n_acc - acc0, 10000);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      budget = 50;
      while (q.size() > 0 && budget > 0) begin
         step();
         budget--;
      end
      chk("rand_drained", q.size(), 0);
      chk("rand_level", bus.level, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
